step_sched: RTL and testbench



---
 rtl/step_sched.sv | 160 ++++++++++++++++
 tb/tb_step_sched.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_sched.sv
// Round-robin scheduler sharing one modulo step counter among NREQ requesters.
// Optional Gray-coded y output: define STEP_SCHED_GRAY_OUT_EN.
module step_sched #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 3,
  parameter int MOD   = 5,
  parameter int LEN_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LEN_W-1:0] req_len,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [WIDTH-1:0]      y
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] y_q;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic             busy_q;

  logic             win_found_s;
  logic [IDX_W-1:0] win_idx_s;
  logic [IDX_W-1:0] cand_s;
  logic [NREQ-1:0]  win_onehot_s;
  logic [LEN_W-1:0] len_s [NREQ];

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NREQ - 1)) ? {IDX_W{1'b0}} : i + IDX_W'(1);
  endfunction

`ifdef STEP_SCHED_GRAY_OUT_EN
  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction
`endif

  for (genvar g = 0; g < NREQ; g++) begin : g_len
    assign len_s[g] = req_len[g*LEN_W +: LEN_W];
  end

  // Winner search: first asserted req at or above the rr pointer, wrapping.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = {IDX_W{1'b0}};
    cand_s      = rr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_found_s && req[cand_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
      cand_s = next_idx(cand_s);
    end
    win_onehot_s = {{(NREQ-1){1'b0}}, 1'b1} << win_idx_s;
  end

  // Next-state logic for the burst FSM and shared counter.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    done_d  = {NREQ{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (win_found_s) begin
          owner_d = win_idx_s;
          grant_d = win_onehot_s;
          rem_d   = len_s[win_idx_s];
          if (len_s[win_idx_s] == {LEN_W{1'b0}}) begin
            state_d = ST_DONE;
            done_d  = win_onehot_s;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // An owner dropping req abandons the burst without advancing.
        if (!req[owner_q]) begin
          grant_d = {NREQ{1'b0}};
          rr_d    = next_idx(owner_q);
          state_d = ST_IDLE;
        end else begin
          count_d = (count_q == WIDTH'(MOD - 1)) ? {WIDTH{1'b0}} : count_q + WIDTH'(1);
          rem_d   = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = ST_DONE;
            done_d  = grant_q;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_DONE: begin
        grant_d = {NREQ{1'b0}};
        rr_d    = next_idx(owner_q);
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = {NREQ{1'b0}};
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; y is derived from count_d to stay aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= {WIDTH{1'b0}};
      y_q     <= {WIDTH{1'b0}};
      rem_q   <= {LEN_W{1'b0}};
      owner_q <= {IDX_W{1'b0}};
      rr_q    <= {IDX_W{1'b0}};
      grant_q <= {NREQ{1'b0}};
      done_q  <= {NREQ{1'b0}};
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
`ifdef STEP_SCHED_GRAY_OUT_EN
      y_q     <= to_gray(count_d);
`else
      y_q     <= count_d;
`endif
      rem_q   <= rem_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign y     = y_q;

endmodule

// File: tb/tb_step_sched.sv
// Self-checking bench for step_sched: directed scenarios plus randomized run
// against a cycle-level behavioural model.
module tb_step_sched;

  localparam int NREQ  = 2;
  localparam int WIDTH = 3;
  localparam int MOD   = 5;
  localparam int LEN_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*LEN_W-1:0] req_len;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [WIDTH-1:0]  y;

  int total = 0;
  int bad   = 0;

  // behavioural model: owner -1 means no burst in progress
  int m_owner = -1;
  int m_left  = 0;
  bit m_fin   = 1'b0;
  int m_rr    = 0;
  int m_count = 0;

  step_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .MOD(MOD), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .req(req), .req_len(req_len),
    .grant(grant), .done(done), .busy(busy), .y(y)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, want finish before 500000");
    $fatal(1);
  end

  function automatic logic [WIDTH-1:0] exp_y(input int c);
`ifdef STEP_SCHED_GRAY_OUT_EN
    return WIDTH'(c ^ (c >> 1));
`else
    return WIDTH'(c);
`endif
  endfunction

  function automatic bit req_bit(input int i);
    return ((req >> i) & 2'b01) != 2'b00;
  endfunction

  task automatic model_step();
    int w;
    if (reset) begin
      m_owner = -1; m_left = 0; m_fin = 1'b0; m_rr = 0; m_count = 0;
    end else if (m_owner < 0) begin
      w = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && req_bit((m_rr + k) % NREQ)) w = (m_rr + k) % NREQ;
      if (w >= 0) begin
        m_owner = w;
        m_left  = int'((req_len >> (w * LEN_W)) & 8'h0F);
        m_fin   = (m_left == 0);
      end
    end else if (m_fin) begin
      m_rr = (m_owner + 1) % NREQ; m_owner = -1; m_fin = 1'b0;
    end else if (!req_bit(m_owner)) begin
      m_rr = (m_owner + 1) % NREQ; m_owner = -1;
    end else begin
      m_count = (m_count + 1) % MOD;
      m_left  = m_left - 1;
      if (m_left == 0) m_fin = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 2'b00; req_len = 8'h00;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (grant !== 2'b00 || done !== 2'b00 || busy !== 1'b0 || y !== 3'b000) begin
      bad++;
      $display("FAIL reset: got grant=%b done=%b busy=%b y=%b want 00 00 0 000", grant, done, busy, y);
    end
  endtask

  task automatic test_basic();
    req = 2'b01; req_len = 8'h03;
    tick();
    total++;
    if (grant !== 2'b01 || busy !== 1'b1 || y !== exp_y(0)) begin
      bad++;
      $display("FAIL basic_grant: got grant=%b busy=%b y=%b want 01 1 %b", grant, busy, y, exp_y(0));
    end
    for (int j = 1; j <= 3; j++) begin
      tick();
      total++;
      if (y !== exp_y(j) || done !== ((j == 3) ? 2'b01 : 2'b00) || grant !== 2'b01) begin
        bad++;
        $display("FAIL basic_step%0d: got y=%b done=%b grant=%b want y=%b", j, y, done, grant, exp_y(j));
      end
    end
    req = 2'b00;
    tick();
    total++;
    if (grant !== 2'b00 || done !== 2'b00 || busy !== 1'b0 || y !== exp_y(3)) begin
      bad++;
      $display("FAIL basic_end: got grant=%b done=%b busy=%b y=%b want 00 00 0 %b", grant, done, busy, y, exp_y(3));
    end
  endtask

  task automatic test_wrap();
    int pulses;
    do_reset();
    pulses = 0;
    req = 2'b01; req_len = 8'h07;
    tick();
    for (int j = 1; j <= 7; j++) begin
      tick();
      if (done == 2'b01) pulses++;
      total++;
      if (y !== exp_y(j % MOD)) begin
        bad++;
        $display("FAIL wrap_step%0d: got y=%b want %b", j, y, exp_y(j % MOD));
      end
    end
    req = 2'b00;
    tick();
    if (done != 2'b00) pulses++;
    total++;
    if (pulses != 1 || y !== exp_y(2) || grant !== 2'b00) begin
      bad++;
      $display("FAIL wrap_end: got pulses=%0d y=%b grant=%b want 1 %b 00", pulses, y, grant, exp_y(2));
    end
  endtask

  task automatic test_arbitration();
    do_reset();
    req = 2'b11; req_len = 8'h22;
    tick();
    total++;
    if (grant !== 2'b01) begin bad++; $display("FAIL arb_first: got %b want 01", grant); end
    tick(); tick();
    total++;
    if (y !== exp_y(2) || done !== 2'b01) begin
      bad++; $display("FAIL arb_done0: got y=%b done=%b want %b 01", y, done, exp_y(2));
    end
    req = 2'b10;
    tick();
    total++;
    if (grant !== 2'b00 || busy !== 1'b0) begin
      bad++; $display("FAIL arb_idle: got grant=%b busy=%b want 00 0", grant, busy);
    end
    tick();
    total++;
    if (grant !== 2'b10) begin bad++; $display("FAIL arb_second: got %b want 10", grant); end
    tick(); tick();
    total++;
    if (y !== exp_y(4) || done !== 2'b10) begin
      bad++; $display("FAIL arb_done1: got y=%b done=%b want %b 10", y, done, exp_y(4));
    end
    req = 2'b11;
    tick(); tick();
    total++;
    if (grant !== 2'b01) begin bad++; $display("FAIL arb_third: got %b want 01", grant); end
    req = 2'b00;
    tick();
    total++;
    if (grant !== 2'b00 || done !== 2'b00 || y !== exp_y(4)) begin
      bad++; $display("FAIL arb_drop: got grant=%b done=%b y=%b want 00 00 %b", grant, done, y, exp_y(4));
    end
  endtask

  task automatic test_zero_len();
    do_reset();
    req = 2'b10; req_len = 8'h00;
    tick();
    total++;
    if (grant !== 2'b10 || done !== 2'b10 || busy !== 1'b1) begin
      bad++; $display("FAIL zero_grant: got grant=%b done=%b busy=%b want 10 10 1", grant, done, busy);
    end
    req = 2'b00;
    tick();
    total++;
    if (grant !== 2'b00 || done !== 2'b00 || busy !== 1'b0 || y !== exp_y(0)) begin
      bad++; $display("FAIL zero_end: got grant=%b done=%b busy=%b y=%b want 00 00 0 %b", grant, done, busy, y, exp_y(0));
    end
  endtask

  task automatic test_abort();
    do_reset();
    req = 2'b01; req_len = 8'h05;
    tick(); tick(); tick();
    req = 2'b00;
    tick();
    total++;
    if (grant !== 2'b00 || done !== 2'b00 || busy !== 1'b0 || y !== exp_y(2)) begin
      bad++; $display("FAIL abort: got grant=%b done=%b busy=%b y=%b want 00 00 0 %b", grant, done, busy, y, exp_y(2));
    end
    req = 2'b11; req_len = 8'h11;
    tick();
    total++;
    if (grant !== 2'b10) begin bad++; $display("FAIL abort_next1: got %b want 10", grant); end
    tick();
    total++;
    if (done !== 2'b10 || y !== exp_y(3)) begin
      bad++; $display("FAIL abort_done1: got done=%b y=%b want 10 %b", done, y, exp_y(3));
    end
    req = 2'b01;
    tick(); tick();
    total++;
    if (grant !== 2'b01) begin bad++; $display("FAIL abort_next0: got %b want 01", grant); end
    tick();
    total++;
    if (done !== 2'b01 || y !== exp_y(4)) begin
      bad++; $display("FAIL abort_done0: got done=%b y=%b want 01 %b", done, y, exp_y(4));
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    req = 2'b01; req_len = 8'h06;
    tick(); tick(); tick(); tick();
    total++;
    if (y !== exp_y(3) || busy !== 1'b1) begin
      bad++; $display("FAIL midrun_pre: got y=%b busy=%b want %b 1", y, busy, exp_y(3));
    end
    reset = 1'b1;
    tick();
    total++;
    if (y !== 3'b000 || grant !== 2'b00 || busy !== 1'b0 || done !== 2'b00) begin
      bad++; $display("FAIL midrun_reset: got y=%b grant=%b busy=%b done=%b want 000 00 0 00", y, grant, busy, done);
    end
    reset = 1'b0; req = 2'b00;
    tick();
    total++;
    if (done !== 2'b00 || busy !== 1'b0) begin
      bad++; $display("FAIL midrun_after: got done=%b busy=%b want 00 0", done, busy);
    end
  endtask

  function automatic logic rnd_req(input int i);
    if (m_owner == i && !m_fin) return ($urandom_range(0, 39) != 0);
    else return 1'($urandom_range(0, 1));
  endfunction

  task automatic test_random();
    logic [NREQ-1:0]  eg, ed;
    logic [WIDTH-1:0] ey;
    logic             eb;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      reset   = ($urandom_range(0, 199) == 0);
      req     = {rnd_req(1), rnd_req(0)};
      req_len = 8'($urandom);
      tick();
      eg = (m_owner >= 0) ? NREQ'(1 << m_owner) : 2'b00;
      ed = (m_owner >= 0 && m_fin) ? NREQ'(1 << m_owner) : 2'b00;
      eb = (m_owner >= 0);
      ey = exp_y(m_count);
      total++;
      if ({grant, done, busy, y} !== {eg, ed, eb, ey}) begin
        bad++;
        if (bad < 20)
          $display("FAIL random cycle %0d: got grant=%b done=%b busy=%b y=%b want %b %b %b %b",
                   n, grant, done, busy, y, eg, ed, eb, ey);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req = 2'b00; req_len = 8'h00;
    test_reset();
    test_basic();
    test_wrap();
    test_arbitration();
    test_zero_len();
    test_abort();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
